// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer
//
// Captures every retired write-back event of the CPU pipeline as a 72-bit
// record {pc[31:0], wena, 2'b00, waddr[4:0], wdata[31:0]} into a FIFO and
// streams the records out MSB-byte first over a valid/ready byte interface.
// The capture side never stalls the pipeline: a record that finds the FIFO
// full (and no pop on the same edge) is dropped and counted.
//
// Ports:
//   clk_in      rising-edge clock for all state
//   reset       asynchronous, active-low reset
//   trace_en    capture enable, sampled every cycle
//   wb_valid    an instruction retires this cycle
//   wb_pc       PC of the retiring instruction
//   wb_wena     regfile write enable of the retiring instruction
//   wb_waddr    regfile write address
//   wb_wdata    regfile write data
//   out_valid   out_data holds a valid trace byte
//   out_data    trace byte
//   out_ready   consumer accepts the byte
//   fifo_level  records held in the FIFO (the record being sent is excluded)
//   overflow    sticky, at least one record was dropped
//   drop_cnt    dropped-record count, saturating at all-ones

module wb_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     trace_en,
  input  logic                     wb_valid,
  input  logic [31:0]              wb_pc,
  input  logic                     wb_wena,
  input  logic [4:0]               wb_waddr,
  input  logic [31:0]              wb_wdata,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [3:0]    LAST_BYTE = 4'd8;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        byte_idx_reg, byte_idx_next;
  logic [71:0]       rec_reg, rec_next;
  logic [AW-1:0]     rd_ptr_reg, wr_ptr_reg;
  logic [LW-1:0]     level_reg;
  logic              overflow_reg;
  logic [DROP_W-1:0] drop_cnt_reg;

  logic [71:0]       mem [DEPTH];
  logic [71:0]       head_rec;
  logic [71:0]       wr_rec;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic [7:0]        rec_byte [9];

  assign wr_rec     = {wb_pc, wb_wena, 2'b00, wb_waddr, wb_wdata};
  // Head is read combinationally so a pop can load the serializer on the
  // same edge it is decided (no bubble between records).
  assign head_rec   = mem[rd_ptr_reg];
  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == DEPTH_L);
  assign push_req   = wb_valid && trace_en;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push_ok    = push_req && (!fifo_full || pop);

  // Serializer next-state logic
  always_comb begin
    state_next    = state_reg;
    byte_idx_next = byte_idx_reg;
    rec_next      = rec_reg;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          rec_next      = head_rec;
          byte_idx_next = 4'd0;
          state_next    = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (byte_idx_reg != LAST_BYTE) begin
            byte_idx_next = byte_idx_reg + 4'd1;
          end else if (!fifo_empty) begin
            pop           = 1'b1;
            rec_next      = head_rec;
            byte_idx_next = 4'd0;
          end else begin
            state_next    = IDLE;
          end
        end
      end
    endcase
  end

  // Control and counters
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      byte_idx_reg <= 4'd0;
      rec_reg      <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      byte_idx_reg <= byte_idx_next;
      rec_reg      <= rec_next;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
      if (push_req && !push_ok) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != '1) begin
          drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
        end
      end
    end
  end

  // Record storage; left unreset so it can map onto RAM.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_rec;
    end
  end

  // Byte 0 is the most significant byte of the record.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_byte
      assign rec_byte[gi] = rec_reg[71-8*gi -: 8];
    end
  endgenerate

  assign out_valid  = (state_reg == SEND);
  assign out_data   = out_valid ? rec_byte[byte_idx_reg] : 8'h00;
  assign fifo_level = level_reg;
  assign overflow   = overflow_reg;
  assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Testbench for wb_trace_buffer. A transaction-level reference model
// (queue of stored records, the record being sent, drop counter) predicts
// the byte stream and status outputs; each scenario task checks inline.

module tb_wb_trace_buffer;

  localparam int DEPTH  = 4;
  localparam int DROP_W = 4;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk_in = 1'b0;
  logic              reset;
  logic              trace_en;
  logic              wb_valid;
  logic [31:0]       wb_pc;
  logic              wb_wena;
  logic [4:0]        wb_waddr;
  logic [31:0]       wb_wdata;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;
  logic [LW-1:0]     fifo_level;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  always #5 clk_in = ~clk_in;

  wb_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .trace_en   (trace_en),
    .wb_valid   (wb_valid),
    .wb_pc      (wb_pc),
    .wb_wena    (wb_wena),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [71:0] mq[$];
  logic        m_busy;
  logic [71:0] m_cur;
  int          m_bidx;
  int          m_drop;
  logic        m_ovf;
  logic [7:0]  rx[$];

  function automatic logic [71:0] mk_rec(logic [31:0] pc, logic wena, logic [4:0] wa, logic [31:0] wd);
    return {pc, wena, 2'b00, wa, wd};
  endfunction

  function automatic logic [7:0] byte_of(logic [71:0] r, int i);
    return r[71-8*i -: 8];
  endfunction

  task automatic model_clear();
    mq.delete();
    rx.delete();
    m_busy = 1'b0;
    m_cur  = '0;
    m_bidx = 0;
    m_drop = 0;
    m_ovf  = 1'b0;
  endtask

  // One clock: log the byte handed over, advance the model, then step the DUT.
  // Called at the falling edge with the inputs for the coming rising edge set.
  task automatic tick();
    int   n;
    logic push;
    logic pop;
    n = mq.size();
    if (out_valid && out_ready) rx.push_back(out_data);
    push = wb_valid && trace_en;
    pop  = (n > 0) && (!m_busy || (out_ready && m_bidx == 8));
    if (m_busy && out_ready) begin
      if (m_bidx < 8) m_bidx++;
      else if (!pop) m_busy = 1'b0;
    end
    if (pop) begin
      m_cur  = mq.pop_front();
      m_busy = 1'b1;
      m_bidx = 0;
    end
    if (push) begin
      if (n < DEPTH || pop) begin
        mq.push_back(mk_rec(wb_pc, wb_wena, wb_waddr, wb_wdata));
      end else begin
        m_ovf = 1'b1;
        if (m_drop < DROP_MAX) m_drop++;
      end
    end
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic set_wb(logic [31:0] pc, logic wena, logic [4:0] wa, logic [31:0] wd);
    wb_valid = 1'b1;
    wb_pc    = pc;
    wb_wena  = wena;
    wb_waddr = wa;
    wb_wdata = wd;
  endtask

  task automatic rand_rec(output logic [71:0] r);
    r = mk_rec($urandom, 1'($urandom), 5'($urandom), $urandom);
    set_wb(r[71:40], r[39], r[36:32], r[31:0]);
  endtask

  task automatic drain(string name, int budget);
    wb_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (!out_valid && fifo_level == '0) break;
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== '0) begin
      errors++;
      $display("FAIL %s_drain: out_valid=%b fifo_level=%0d, required idle and empty", name, out_valid, fifo_level);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_fifo_level: got %0d want 0", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    @(negedge clk_in);
    @(negedge clk_in);
    reset = 1'b1;
    model_clear();
    @(negedge clk_in);
  endtask

  task automatic test_single_record();
    logic [7:0] exp_b [9] = '{8'h00, 8'h40, 8'h00, 8'h04, 8'h9F, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] got;
    int nvalid;
    rx.delete();
    out_ready = 1'b1;
    set_wb(32'h0040_0004, 1'b1, 5'd31, 32'hDEAD_BEEF);
    tick();
    wb_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after_push: got %b want 0", out_valid); end
    checks++; if (fifo_level !== LW'(1)) begin errors++; $display("FAIL single_level_after_push: got %0d want 1", fifo_level); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_latency: got %b want 1", out_valid); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL single_level_after_pop: got %0d want 0", fifo_level); end
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      if (!out_valid) break;
      nvalid++;
      tick();
    end
    checks++; if (nvalid != 9) begin errors++; $display("FAIL single_valid_cycles: got %0d want 9", nvalid); end
    checks++; if (rx.size() != 9) begin errors++; $display("FAIL single_byte_count: got %0d want 9", rx.size()); end
    for (int i = 0; i < 9; i++) begin
      got = (i < rx.size()) ? rx[i] : 8'hxx;
      checks++;
      if (got !== exp_b[i]) begin errors++; $display("FAIL single_byte%0d: got %h want %h", i, got, exp_b[i]); end
    end
    $display("single record: %0d bytes, %0d valid cycles", rx.size(), nvalid);
  endtask

  task automatic test_back_to_back();
    logic [71:0] recs [3];
    logic [7:0]  got;
    int nvalid;
    rx.delete();
    out_ready = 1'b1;
    nvalid = 0;
    for (int k = 0; k < 3; k++) begin
      rand_rec(recs[k]);
      if (out_valid) nvalid++;
      tick();
      checks++;
      if (fifo_level !== LW'(mq.size())) begin
        errors++; $display("FAIL b2b_level%0d: got %0d want %0d", k, fifo_level, mq.size());
      end
    end
    wb_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!out_valid) break;
      nvalid++;
      tick();
    end
    checks++; if (nvalid != 27) begin errors++; $display("FAIL b2b_gapless_cycles: got %0d want 27", nvalid); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL b2b_level_end: got %0d want 0", fifo_level); end
    for (int i = 0; i < 27; i++) begin
      got = (i < rx.size()) ? rx[i] : 8'hxx;
      checks++;
      if (got !== byte_of(recs[i/9], i%9)) begin
        errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, got, byte_of(recs[i/9], i%9));
      end
    end
    $display("back-to-back: %0d bytes in %0d valid cycles", rx.size(), nvalid);
  endtask

  task automatic test_backpressure();
    logic [71:0] r;
    logic [7:0]  held;
    logic [7:0]  got;
    logic        stalled;
    logic        phase;
    int nvalid;
    rx.delete();
    out_ready = 1'b0;
    rand_rec(r);
    tick();
    wb_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) break;
      tick();
    end
    nvalid  = 0;
    stalled = 1'b0;
    phase   = 1'b1;
    held    = 8'h00;
    for (int i = 0; i < 40; i++) begin
      if (!out_valid) break;
      nvalid++;
      if (stalled) begin
        checks++;
        if (out_data !== held) begin errors++; $display("FAIL bp_stable_cycle%0d: got %h want %h", nvalid, out_data, held); end
      end
      out_ready = phase;
      stalled   = !phase;
      held      = out_data;
      phase     = !phase;
      tick();
    end
    out_ready = 1'b0;
    checks++; if (nvalid != 17) begin errors++; $display("FAIL bp_record_cycles: got %0d want 17", nvalid); end
    for (int i = 0; i < 9; i++) begin
      got = (i < rx.size()) ? rx[i] : 8'hxx;
      checks++;
      if (got !== byte_of(r, i)) begin errors++; $display("FAIL bp_byte%0d: got %h want %h", i, got, byte_of(r, i)); end
    end
    $display("backpressure: record took %0d cycles", nvalid);
  endtask

  task automatic test_overflow();
    logic [71:0] recs [6];
    logic [7:0]  got;
    rx.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rand_rec(recs[k]);
      tick();
    end
    wb_valid = 1'b0;
    checks++; if (fifo_level !== LW'(4)) begin errors++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
    checks++; if (drop_cnt !== DROP_W'(1)) begin errors++; $display("FAIL ovf_drop_cnt: got %0d want 1", drop_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_shift_reg_held: got %b want 1", out_valid); end
    drain("ovf", 80);
    checks++; if (rx.size() != 45) begin errors++; $display("FAIL ovf_byte_count: got %0d want 45", rx.size()); end
    for (int i = 0; i < 45; i++) begin
      got = (i < rx.size()) ? rx[i] : 8'hxx;
      checks++;
      if (got !== byte_of(recs[i/9], i%9)) begin
        errors++; $display("FAIL ovf_byte%0d: got %h want %h", i, got, byte_of(recs[i/9], i%9));
      end
    end
    $display("overflow: drop_cnt=%0d, %0d records received", drop_cnt, rx.size() / 9);
  endtask

  task automatic test_saturation();
    logic [71:0] r;
    out_ready = 1'b0;
    for (int k = 0; k < 25; k++) begin
      rand_rec(r);
      tick();
    end
    wb_valid = 1'b0;
    checks++; if (drop_cnt !== DROP_W'(DROP_MAX)) begin errors++; $display("FAIL sat_drop_cnt: got %0d want %0d", drop_cnt, DROP_MAX); end
    checks++; if (drop_cnt !== DROP_W'(m_drop)) begin errors++; $display("FAIL sat_drop_model: got %0d want %0d", drop_cnt, m_drop); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow: got %b want 1", overflow); end
    checks++; if (fifo_level !== LW'(DEPTH)) begin errors++; $display("FAIL sat_level: got %0d want %0d", fifo_level, DEPTH); end
    drain("sat", 80);
    $display("saturation: drop_cnt=%0d", drop_cnt);
  endtask

  task automatic test_reset_mid_record();
    logic [71:0] r;
    logic [7:0]  got;
    rx.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_rec(r);
      tick();
    end
    wb_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rx.size() >= 3) break;
      tick();
    end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_mid_out_data: got %h want 00", out_data); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rst_mid_level: got %0d want 0", fifo_level); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL rst_mid_drop_cnt: got %0d want 0", drop_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_mid_overflow: got %b want 0", overflow); end
    @(negedge clk_in);
    reset = 1'b1;
    model_clear();
    @(negedge clk_in);
    rand_rec(r);
    tick();
    drain("rst_mid", 30);
    checks++; if (rx.size() != 9) begin errors++; $display("FAIL rst_mid_byte_count: got %0d want 9", rx.size()); end
    for (int i = 0; i < 9; i++) begin
      got = (i < rx.size()) ? rx[i] : 8'hxx;
      checks++;
      if (got !== byte_of(r, i)) begin errors++; $display("FAIL rst_mid_byte%0d: got %h want %h", i, got, byte_of(r, i)); end
    end
    $display("reset mid-record: %0d bytes after release", rx.size());
  endtask

  task automatic test_gating();
    logic [7:0] got;
    logic [71:0] r;
    rx.delete();
    out_ready = 1'b1;
    trace_en  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_wb($urandom, 1'b1, 5'($urandom), $urandom);
      tick();
      wb_valid = 1'b0;
      tick();
    end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL gate_level: got %0d want 0", fifo_level); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gate_out_valid: got %b want 0", out_valid); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL gate_drop_cnt: got %0d want 0", drop_cnt); end
    checks++; if (rx.size() != 0) begin errors++; $display("FAIL gate_bytes: got %0d want 0", rx.size()); end
    trace_en = 1'b1;
    r = mk_rec($urandom, 1'b0, 5'd5, $urandom);
    set_wb(r[71:40], 1'b0, 5'd5, r[31:0]);
    tick();
    drain("gate", 30);
    got = (rx.size() > 4) ? rx[4] : 8'hxx;
    checks++; if (got !== 8'h05) begin errors++; $display("FAIL gate_byte4: got %h want 05", got); end
    for (int i = 0; i < 9; i++) begin
      got = (i < rx.size()) ? rx[i] : 8'hxx;
      checks++;
      if (got !== byte_of(r, i)) begin errors++; $display("FAIL gate_byte%0d: got %h want %h", i, got, byte_of(r, i)); end
    end
    $display("gating: byte4=%h", (rx.size() > 4) ? rx[4] : 8'hxx);
  endtask

  task automatic test_random();
    logic [7:0] exp_d;
    logic [71:0] r;
    for (int c = 0; c < 600; c++) begin
      checks++;
      if (fifo_level !== LW'(mq.size())) begin errors++; $display("FAIL rnd_level c%0d: got %0d want %0d", c, fifo_level, mq.size()); end
      checks++;
      if (out_valid !== m_busy) begin errors++; $display("FAIL rnd_out_valid c%0d: got %b want %b", c, out_valid, m_busy); end
      if (m_busy) begin
        exp_d = byte_of(m_cur, m_bidx);
        checks++;
        if (out_data !== exp_d) begin errors++; $display("FAIL rnd_out_data c%0d: got %h want %h", c, out_data, exp_d); end
      end
      checks++;
      if (drop_cnt !== DROP_W'(m_drop)) begin errors++; $display("FAIL rnd_drop_cnt c%0d: got %0d want %0d", c, drop_cnt, m_drop); end
      checks++;
      if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow c%0d: got %b want %b", c, overflow, m_ovf); end
      rand_rec(r);
      wb_valid  = ($urandom % 4) != 0;
      trace_en  = ($urandom % 8) != 0;
      out_ready = ($urandom % 3) != 0;
      tick();
    end
    trace_en = 1'b1;
    drain("rnd", 80);
    $display("random: drop_cnt=%0d overflow=%b", drop_cnt, overflow);
  endtask

  initial begin
    reset     = 1'b0;
    trace_en  = 1'b1;
    wb_valid  = 1'b0;
    wb_pc     = '0;
    wb_wena   = 1'b0;
    wb_waddr  = '0;
    wb_wdata  = '0;
    out_ready = 1'b0;
    model_clear();
    test_reset();
    test_single_record();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_saturation();
    test_reset_mid_record();
    test_gating();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
